// File: rtl/mem_arb_pkg.sv
// Shared encodings and lane helpers for the I/D memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] MEMOP_NONE = 2'b00;
  localparam logic [1:0] MEMOP_LDS  = 2'b01;
  localparam logic [1:0] MEMOP_LDU  = 2'b10;
  localparam logic [1:0] MEMOP_ST   = 2'b11;

  localparam logic [1:0] MEMSIZE_B  = 2'b00;
  localparam logic [1:0] MEMSIZE_H  = 2'b01;
  localparam logic [1:0] MEMSIZE_W  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } arbState_t;

  // Byte offset after dropping the address bits finer than the access size.
  function automatic logic [1:0] alignOff(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MEMSIZE_B: alignOff = a;
      MEMSIZE_H: alignOff = {a[1], 1'b0};
      default:   alignOff = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MEMSIZE_B: laneMask = 4'b0001 << a;
      MEMSIZE_H: laneMask = 4'b0011 << {a[1], 1'b0};
      default:   laneMask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load extract/extend.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  stSize,
  input  logic [1:0]  stAddrLo,
  input  logic [31:0] stData,
  output logic [3:0]  stWen,
  output logic [31:0] stDin,
  input  logic [1:0]  ldSize,
  input  logic [1:0]  ldAddrLo,
  input  logic        ldSigned,
  input  logic [31:0] ldRaw,
  output logic [31:0] ldData
);

  logic [31:0] shifted;

  assign stWen   = laneMask(stSize, stAddrLo);
  assign shifted = ldRaw >> {alignOff(ldSize, ldAddrLo), 3'b000};

  always_comb begin
    stDin = stData;
    case (stSize)
      MEMSIZE_B: stDin = {4{stData[7:0]}};
      MEMSIZE_H: stDin = {2{stData[15:0]}};
      default:   stDin = stData;
    endcase
  end

  always_comb begin
    ldData = shifted;
    case (ldSize)
      MEMSIZE_B: ldData = ldSigned ? {{24{shifted[7]}}, shifted[7:0]}  : {24'h0, shifted[7:0]};
      MEMSIZE_H: ldData = ldSigned ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default:   ldData = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Single-port RAM/ROM arbiter between fetch (I) and load/store (D), one read in flight.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int RAM_SEL_BIT  = 31,
  parameter int D_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [1:0]  d_op,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_en,
  output logic        rom_en,
  output logic [3:0]  mem_wen,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (D_STREAK_MAX > 0) ? $clog2(D_STREAK_MAX + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

  arbState_t   state, stateNext;
  logic [LW-1:0] latCnt, latNext;
  logic [SW-1:0] streak;
  logic        ownerD, ldSignQ;
  logic [1:0]  ldOffQ, ldSizeQ;
  logic [31:0] iRdataQ, dRdataQ, ldData;
  logic        iRvalidQ, dRvalidQ;
  logic        inIdle, dWants, pickD, pickI, startRead, misalign, capture;
  logic [3:0]  stWen;
  logic        unusedBits;

  assign unusedBits = ^i_addr[1:0];

  assign inIdle  = (state == ST_IDLE) && !rst;
  assign dWants  = d_req && (d_op != MEMOP_NONE);
  // I only overrides D once D has taken STREAK_MAX grants in a row while I waited.
  assign pickD   = inIdle && dWants && !(i_req && streak == STREAK_MAX);
  assign pickI   = inIdle && i_req && !pickD;
  assign capture = (state == ST_RD_WAIT) && (latCnt == '0);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (d_size == MEMSIZE_H) ? d_addr[0]
                  : (d_size != MEMSIZE_B) && (d_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_addr = pickI ? i_addr[31:2] : d_addr[31:2];

  mem_lane_align uAlign (
    .stSize  (d_size),
    .stAddrLo(d_addr[1:0]),
    .stData  (d_wdata),
    .stWen   (stWen),
    .stDin   (mem_din),
    .ldSize  (ldSizeQ),
    .ldAddrLo(ldOffQ),
    .ldSigned(ldSignQ),
    .ldRaw   (mem_dout),
    .ldData  (ldData)
  );

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    d_err     = 1'b0;
    ram_en    = 1'b0;
    rom_en    = 1'b0;
    mem_wen   = 4'b0000;
    startRead = 1'b0;
    stateNext = state;
    latNext   = latCnt;
    case (state)
      ST_IDLE: begin
        if (pickD) begin
          d_gnt = 1'b1;
          if (misalign) begin
            d_err = 1'b1;
          end else if (d_op == MEMOP_ST) begin
            // Stores complete in the grant cycle; ROM stores are refused.
            if (d_addr[RAM_SEL_BIT]) begin
              ram_en  = 1'b1;
              mem_wen = stWen;
            end else begin
              d_err = 1'b1;
            end
          end else begin
            ram_en    = d_addr[RAM_SEL_BIT];
            rom_en    = !d_addr[RAM_SEL_BIT];
            startRead = 1'b1;
          end
        end else if (pickI) begin
          i_gnt     = 1'b1;
          ram_en    = i_addr[RAM_SEL_BIT];
          rom_en    = !i_addr[RAM_SEL_BIT];
          startRead = 1'b1;
        end
        if (startRead) begin
          stateNext = ST_RD_WAIT;
          latNext   = LW'(MEM_LAT - 1);
        end
      end
      ST_RD_WAIT: begin
        if (latCnt == '0) stateNext = ST_RESP;
        else              latNext   = latCnt - 1'b1;
      end
      ST_RESP:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      latCnt   <= '0;
      streak   <= '0;
      ownerD   <= 1'b0;
      ldOffQ   <= 2'b00;
      ldSizeQ  <= 2'b00;
      ldSignQ  <= 1'b0;
      iRdataQ  <= '0;
      dRdataQ  <= '0;
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
    end else begin
      state    <= stateNext;
      latCnt   <= latNext;
      iRvalidQ <= 1'b0;
      dRvalidQ <= 1'b0;
      if (pickD)
        streak <= !i_req ? '0 : (streak == STREAK_MAX) ? streak : streak + 1'b1;
      else if (state == ST_IDLE)
        streak <= '0;
      if (startRead) begin
        ownerD  <= pickD;
        ldOffQ  <= d_addr[1:0];
        ldSizeQ <= d_size;
        ldSignQ <= (d_op == MEMOP_LDS);
      end
      // Data is valid on the last wait cycle, so rvalid lands in RESP.
      if (capture) begin
        if (ownerD) begin
          dRdataQ  <= ldData;
          dRvalidQ <= 1'b1;
        end else begin
          iRdataQ  <= mem_dout;
          iRvalidQ <= 1'b1;
        end
      end
    end
  end

  assign i_rvalid = iRvalidQ;
  assign d_rvalid = dRvalidQ;
  assign i_rdata  = iRdataQ;
  assign d_rdata  = dRdataQ;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized scoreboard bench for mem_access_arbiter with a byte-addressed reference memory.
module tb_mem_access_arbiter;

  localparam int MEM_LAT = 1;

  typedef struct packed {
    logic        err;
    logic        isLoad;
    logic        isRam;
    logic [3:0]  wen;
    logic [31:0] din;
    logic [31:0] rdata;
  } dExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_op, d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ram_en, rom_en;
  logic [3:0]  mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] romWords [64];
  logic [31:0] ramInit  [64];
  logic [31:0] memRam   [64];
  logic [7:0]  refRamB  [256];
  logic        loadMem;
  logic [31:0] memDoutQ = 32'h0;

  dExp_t       dIssueQ[$], dPendQ[$];
  int          dPendCyc[$], iPendCyc[$];
  logic [31:0] iIssueQ[$], iPendQ[$];
  logic        gntLogEn = 1'b0;
  logic        gntLog[$];

  mem_access_arbiter #(.MEM_LAT(MEM_LAT), .RAM_SEL_BIT(31), .D_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_op(d_op), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .rom_en(rom_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory macros: one-cycle read latency, byte-enabled RAM writes.
  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 64; i++) memRam[i] <= ramInit[i];
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) memRam[mem_addr[5:0]][8*b +: 8] <= mem_din[8*b +: 8];
    end
    if (ram_en)      memDoutQ <= memRam[mem_addr[5:0]];
    else if (rom_en) memDoutQ <= romWords[mem_addr[5:0]];
  end
  assign mem_dout = memDoutQ;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [7:0] refByte(input logic [31:0] a);
    logic [31:0] w;
    if (a[31]) return refRamB[a[7:0]];
    w = romWords[a[7:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic doD(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    dExp_t e;
    int n, w;
    logic [31:0] base, v;
    e = '0;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = a & ~32'(n - 1);
    if (op != 2'd0) begin
      if (misal(sz, a)) e.err = 1'b1;
      else if (op == 2'd3) begin
        if (!a[31]) e.err = 1'b1;
        else begin
          e.isRam = 1'b1;
          for (int k = 0; k < n; k++) begin
            refRamB[8'(base[7:0] + k)] = wd[8*k +: 8];
            e.wen[base[1:0] + k] = 1'b1;
          end
          e.din = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        end
      end else begin
        e.isLoad = 1'b1;
        e.isRam  = a[31];
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = refByte(base + 32'(k));
        if (n < 4 && op == 2'd1 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
        e.rdata = v;
      end
      dIssueQ.push_back(e);
    end
    d_req = 1'b1; d_op = op; d_size = sz; d_addr = a; d_wdata = wd;
    if (op == 2'd0) begin
      repeat (3) @(posedge clk);
      #1 d_req = 1'b0;
      return;
    end
    w = 0;
    forever begin
      @(negedge clk);
      if (d_gnt) break;
      w++;
      if (w >= 200) begin failNow("d_gnt timeout"); break; end
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic doI(input logic [31:0] a);
    int w;
    iIssueQ.push_back(romWords[a[7:2]]);
    i_req = 1'b1; i_addr = a;
    w = 0;
    forever begin
      @(negedge clk);
      if (i_gnt) break;
      w++;
      if (w >= 200) begin failNow("i_gnt timeout"); break; end
    end
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT grants or returns data.
  always @(negedge clk) begin
    dExp_t e;
    int pc;
    if (!rst) begin
      if (d_gnt && i_gnt) failNow("both grants in one cycle");
      if (d_gnt) begin
        if (dIssueQ.size() == 0) failNow("unexpected d_gnt");
        else begin
          e = dIssueQ.pop_front();
          chk("d_err", 32'(d_err), 32'(e.err));
          chk("ram_en on d_gnt", 32'(ram_en), 32'(!e.err && e.isRam));
          chk("rom_en on d_gnt", 32'(rom_en), 32'(!e.err && e.isLoad && !e.isRam));
          chk("mem_wen", 32'(mem_wen), 32'(e.wen));
          if (e.wen != 4'b0) chk("mem_din", mem_din, e.din);
          if (e.isLoad) begin dPendQ.push_back(e); dPendCyc.push_back(cyc); end
          if (gntLogEn) gntLog.push_back(1'b1);
        end
      end else if (d_err) failNow("d_err without d_gnt");
      if (i_gnt) begin
        if (iIssueQ.size() == 0) failNow("unexpected i_gnt");
        else begin
          chk("rom_en on i_gnt", 32'({rom_en, ram_en}), 32'd2);
          iPendQ.push_back(iIssueQ.pop_front());
          iPendCyc.push_back(cyc);
          if (gntLogEn) gntLog.push_back(1'b0);
        end
      end
      if (d_rvalid) begin
        if (dPendQ.size() == 0) failNow("unexpected d_rvalid");
        else begin
          e = dPendQ.pop_front();
          pc = dPendCyc.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d latency", 32'(cyc - pc), 32'(MEM_LAT + 1));
        end
      end
      if (i_rvalid) begin
        if (iPendQ.size() == 0) failNow("unexpected i_rvalid");
        else begin
          pc = iPendCyc.pop_front();
          chk("i_rdata", i_rdata, iPendQ.pop_front());
          chk("i latency", 32'(cyc - pc), 32'(MEM_LAT + 1));
        end
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < 64; i++) begin
      romWords[i] = $urandom;
      ramInit[i]  = $urandom;
      for (int b = 0; b < 4; b++) refRamB[4*i + b] = ramInit[i][8*b +: 8];
    end
    loadMem = 1'b1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_op = 2'd3; d_size = 2'd2; d_addr = 32'h8000_0000; d_wdata = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset i_gnt", 32'(i_gnt), 32'd0);
    chk("reset d_gnt", 32'(d_gnt), 32'd0);
    chk("reset d_err", 32'(d_err), 32'd0);
    chk("reset enables", 32'({ram_en, rom_en}), 32'd0);
    chk("reset mem_wen", 32'(mem_wen), 32'd0);
    chk("reset rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    chk("reset i_rdata", i_rdata, 32'd0);
    chk("reset d_rdata", d_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; loadMem = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // Byte store to the top lane, then signed/unsigned byte loads.
    doD(2'd3, 2'd0, 32'h8000_0003, 32'h0000_00AB);
    doD(2'd3, 2'd2, 32'h8000_0000, 32'h0000_8000);
    doD(2'd1, 2'd0, 32'h8000_0001, 32'h0);
    doD(2'd2, 2'd0, 32'h8000_0001, 32'h0);
    // Store to ROM, misaligned half load.
    doD(2'd3, 2'd2, 32'h0000_0010, 32'h1234_5678);
    doD(2'd1, 2'd1, 32'h8000_0001, 32'h0);

    // Both requesters held: D,D,D,D,I repeating.
    repeat (3) @(posedge clk);
    #1 gntLogEn = 1'b1;
    fork
      begin for (int k = 0; k < 12; k++) doD(2'd3, 2'd2, 32'h8000_0040 + 32'(4*k), $urandom); end
      begin for (int k = 0; k < 3; k++) doI(32'h0000_0020 + 32'(4*k)); end
    join
    gntLogEn = 1'b0;
    chk("grant count", 32'(gntLog.size()), 32'd15);
    for (int g = 0; g < gntLog.size() && g < 15; g++)
      chk($sformatf("grant order %0d", g), 32'(gntLog[g]), (g % 5 == 4) ? 32'd0 : 32'd1);

    // Reset while a load waits: the read is abandoned.
    repeat (4) @(posedge clk);
    #1;
    doD(2'd2, 2'd2, 32'h8000_0004, 32'h0);
    rst = 1'b1;
    dPendQ.delete();
    dPendCyc.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    chk("post-reset d_rdata", d_rdata, 32'd0);
    chk("post-reset i_rdata", i_rdata, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    doD(2'd1, 2'd1, 32'h8000_0006, 32'h0);

    // Random traffic from both sides.
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          doD(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0 ? 32'h8000_0000 : 32'h0) | ($urandom & 32'hFF), $urandom);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          doI($urandom & 32'hFC);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join

    w = 0;
    while ((dPendQ.size() != 0 || iPendQ.size() != 0) && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("d issue drained", 32'(dIssueQ.size()), 32'd0);
    chk("i issue drained", 32'(iIssueQ.size()), 32'd0);
    chk("d loads drained", 32'(dPendQ.size()), 32'd0);
    chk("i fetches drained", 32'(iPendQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
